// File: rtl/caliptra_axi_sram_ctrl.sv
// Single-port SRAM controller with a power-on/zeroize sweep, a fixed-latency read pipeline,
// and optional per-byte even parity (enabled by defining CALIPTRA_AXI_SRAM_PARITY_EN).
module caliptra_axi_sram_ctrl #(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int DEPTH = 1024,
    parameter int C_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dv,
    input  logic [AW-1:0]   addr,
    input  logic            write,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            err_inj,
    output logic [DW-1:0]   rdata,
    output logic            rd_err,
    output logic            wr_err,
    output logic            hld,
    input  logic            zeroize_req,
    output logic            init_done
);

    localparam int BC = DW / 8;
    localparam int BW = $clog2(BC);
    localparam int IW = AW - BW;
    localparam int MW = $clog2(DEPTH);
    localparam int CW = MW + 1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sweep_we;
    logic [MW-1:0] sweep_idx;

    logic [IW-1:0] word_idx;
    logic [MW-1:0] mem_idx;
    logic          in_range;
    logic          acc;
    logic          rd_acc;
    logic          wr_acc;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_word;
    logic          rd_par_err;
    logic          rd_fault;

    logic [C_LAT:1] pipe_vld;
    logic [C_LAT:1] pipe_err;
    logic [DW-1:0]  pipe_data [1:C_LAT];

    // ------------------------------------------------------------------
    // Request decode: the byte offset within a word is ignored
    // ------------------------------------------------------------------
    assign word_idx = addr[AW-1:BW];
    assign mem_idx  = word_idx[MW-1:0];
    assign in_range = {1'b0, word_idx} < (IW + 1)'(DEPTH);

    assign acc    = dv && !hld;
    assign rd_acc = acc && !write;
    assign wr_acc = acc && write && in_range;
    assign wr_err = acc && write && !in_range;

    if (BW > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^addr[BW-1:0];
    end

    // ------------------------------------------------------------------
    // Sweep FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (zeroize_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        hld       = 1'b1;
        init_done = 1'b0;
        sweep_we  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                hld      = 1'b1;
                sweep_we = 1'b1;
            end
            ST_READY: begin
                hld       = 1'b0;
                init_done = 1'b1;
            end
        endcase
    end

    assign sweep_idx = cnt_q[MW-1:0];

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the array has no reset; it is cleared only by the sweep, which keeps it mappable to SRAM.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_idx] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BC; i++) begin
                if (wstrb[i]) begin
                    mem[mem_idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

`ifdef CALIPTRA_AXI_SRAM_PARITY_EN
    logic [BC-1:0] par_mem [DEPTH];
    logic [BC-1:0] wr_par;

    function automatic logic [BC-1:0] byte_par(input logic [DW-1:0] d);
        logic [BC-1:0] p;
        for (int i = 0; i < BC; i++) begin
            p[i] = ^d[i*8 +: 8];
        end
        return p;
    endfunction

    assign wr_par = byte_par(wdata);

    // err_inj flips only byte 0's parity so a later read of this word flags an error
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            par_mem[sweep_idx] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BC; i++) begin
                if (wstrb[i]) begin
                    par_mem[mem_idx][i] <= (i == 0 && err_inj) ? ~wr_par[i] : wr_par[i];
                end
            end
        end
    end

    assign rd_par_err = in_range && (|(par_mem[mem_idx] ^ byte_par(mem[mem_idx])));
`else
    logic unused_err_inj;
    assign unused_err_inj = err_inj;
    assign rd_par_err     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read pipeline: storage is sampled at the acceptance edge, so later
    // writes or a zeroize sweep cannot disturb a read already in flight.
    // ------------------------------------------------------------------
    assign rd_word  = in_range ? mem[mem_idx] : '0;
    assign rd_fault = !in_range || rd_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 1; i <= C_LAT; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[1] <= rd_acc;
            pipe_err[1] <= rd_fault;
            if (rd_acc) begin
                pipe_data[1] <= rd_word;
            end
            for (int i = 2; i <= C_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    // Data stages only advance on valid reads, so rdata holds between reads
    assign rdata  = pipe_data[C_LAT];
    assign rd_err = pipe_vld[C_LAT] && pipe_err[C_LAT];

endmodule

// File: tb/tb_caliptra_axi_sram_ctrl.sv
// Directed bench for caliptra_axi_sram_ctrl: reference model plus read scoreboard checked by a negedge monitor.
module tb_caliptra_axi_sram_ctrl;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int C_LAT = 3;
`ifdef CALIPTRA_AXI_SRAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          dv = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          write = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [7:0]    wstrb = '0;
    logic          err_inj = 1'b0;
    logic [DW-1:0] rdata;
    logic          rd_err;
    logic          wr_err;
    logic          hld;
    logic          zeroize_req = 1'b0;
    logic          init_done;

    caliptra_axi_sram_ctrl #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .C_LAT(C_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dv(dv), .addr(addr), .write(write),
        .wdata(wdata), .wstrb(wstrb), .err_inj(err_inj), .rdata(rdata),
        .rd_err(rd_err), .wr_err(wr_err), .hld(hld),
        .zeroize_req(zeroize_req), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [DEPTH];
    logic        par_bad [DEPTH];
    logic [63:0] last_rdata = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) begin
            model[i]   = '0;
            par_bad[i] = 1'b0;
        end
    endtask

    // Issue one request starting at posedge+1; returns just after its acceptance edge.
    task automatic req(input logic wr, input logic [31:0] a, input logic [63:0] wd,
                       input logic [7:0] ws, input logic ei);
        logic [28:0] idx;
        logic        inr;
        idx     = a[31:3];
        inr     = idx < 29'(DEPTH);
        dv      = 1'b1;
        write   = wr;
        addr    = a;
        wdata   = wd;
        wstrb   = ws;
        err_inj = ei;
        @(negedge clk);
        check("wr_err", {63'd0, wr_err}, {63'd0, wr && !inr});
        @(posedge clk);
        #1;
        if (!wr) begin
            sb.push_back('{due: cyc + C_LAT - 1,
                           data: inr ? model[idx[3:0]] : 64'd0,
                           err: !inr || (PAR_EN && par_bad[idx[3:0]])});
        end else if (inr) begin
            for (int b = 0; b < 8; b++) begin
                if (ws[b]) model[idx[3:0]][b*8 +: 8] = wd[b*8 +: 8];
            end
            if (ws[0]) par_bad[idx[3:0]] = ei;
        end
        dv      = 1'b0;
        err_inj = 1'b0;
    endtask

    // Read results are compared in their latency slot; otherwise rdata must hold and rd_err stay low.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            last_rdata = '0;
            check("rst_rdata", rdata, 64'd0);
            check("rst_rd_err", {63'd0, rd_err}, 64'd0);
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rdata", rdata, e.data);
            check("rd_err", {63'd0, rd_err}, {63'd0, e.err});
            last_rdata = e.data;
        end else begin
            check("rd_err_idle", {63'd0, rd_err}, 64'd0);
            check("rdata_hold", rdata, last_rdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        zero_model();

        // Reset state, with an out-of-range write request held on the bus
        #2 rst_n = 1'b0;
        dv = 1'b1; write = 1'b1; addr = 32'h80;
        @(negedge clk);
        check("rst_hld", {63'd0, hld}, 64'd1);
        check("rst_init_done", {63'd0, init_done}, 64'd0);
        check("rst_wr_err", {63'd0, wr_err}, 64'd0);
        dv = 1'b0; write = 1'b0; addr = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Sweep after reset: stalled for exactly DEPTH cycles
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check($sformatf("init_hld_%0d", i), {62'd0, hld, init_done}, 64'd2);
        end
        @(negedge clk);
        check("init_ready", {62'd0, hld, init_done}, 64'd1);
        sync();

        // Every word reads zero, back to back
        for (int i = 0; i < DEPTH; i++) req(1'b0, 32'(i * 8), '0, '0, 1'b0);
        idle(C_LAT + 1);

        // Full then partial write, read immediately after, offset bits ignored, wstrb=0 no-op
        req(1'b1, 32'h40, 64'h1122334455667788, 8'hFF, 1'b0);
        req(1'b1, 32'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0);
        req(1'b0, 32'h40, '0, '0, 1'b0);
        req(1'b0, 32'h47, '0, '0, 1'b0);
        req(1'b1, 32'h40, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0);
        req(1'b0, 32'h40, '0, '0, 1'b0);
        idle(C_LAT + 1);

        // Pipelined back-to-back reads at the configured latency
        req(1'b1, 32'h00, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
        req(1'b1, 32'h08, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0);
        req(1'b1, 32'h10, 64'h5555AAAA3333CCCC, 8'hFF, 1'b1);
        req(1'b0, 32'h00, '0, '0, 1'b0);
        req(1'b0, 32'h08, '0, '0, 1'b0);
        req(1'b0, 32'h10, '0, '0, 1'b0);
        idle(C_LAT + 1);

        // Range boundary: last word valid, first word past the end rejected
        req(1'b1, 32'h78, 64'hFEEDFACE00C0FFEE, 8'hFF, 1'b0);
        req(1'b1, 32'h80, 64'h9999999999999999, 8'hFF, 1'b0);
        req(1'b0, 32'h00, '0, '0, 1'b0);
        req(1'b0, 32'h80, '0, '0, 1'b0);
        req(1'b0, 32'h78, '0, '0, 1'b0);
        req(1'b0, 32'h3F8, '0, '0, 1'b0);
        idle(C_LAT + 2);

`ifdef CALIPTRA_AXI_SRAM_PARITY_EN
        // Injected parity error on byte 0, cleared by a clean rewrite
        req(1'b1, 32'h08, 64'h000000000000005A, 8'h01, 1'b1);
        req(1'b0, 32'h08, '0, '0, 1'b0);
        req(1'b1, 32'h08, 64'h000000000000005A, 8'h01, 1'b0);
        req(1'b0, 32'h08, '0, '0, 1'b0);
        req(1'b1, 32'h18, 64'h0000000000001200, 8'h02, 1'b1);
        req(1'b0, 32'h18, '0, '0, 1'b0);
        idle(C_LAT + 1);
`endif

        // Zeroize with a read accepted the same cycle; a second pulse mid-sweep is ignored
        dv = 1'b1; write = 1'b0; addr = 32'h40; zeroize_req = 1'b1;
        @(negedge clk);
        check("zero_acc_hld", {63'd0, hld}, 64'd0);
        @(posedge clk);
        #1;
        sb.push_back('{due: cyc + C_LAT - 1, data: model[8], err: PAR_EN && par_bad[8]});
        zero_model();
        dv = 1'b0; zeroize_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check($sformatf("zero_hld_%0d", i), {62'd0, hld, init_done}, 64'd2);
            if (i == 4) zeroize_req = 1'b1;
            if (i == 5) zeroize_req = 1'b0;
        end
        @(negedge clk);
        check("zero_ready", {62'd0, hld, init_done}, 64'd1);
        sync();
        for (int i = 0; i < DEPTH; i++) req(1'b0, 32'(i * 8), '0, '0, 1'b0);
        idle(C_LAT + 1);

        // Reset while a read is in flight: result discarded, sweep restarts
        req(1'b1, 32'h18, 64'h7777666655554444, 8'hFF, 1'b0);
        req(1'b0, 32'h18, '0, '0, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 4 * DEPTH) begin
            @(negedge clk);
            n++;
        end
        check("reinit_cycles", 64'(n), 64'(DEPTH + 1));
        zero_model();
        sync();
        req(1'b0, 32'h18, '0, '0, 1'b0);
        idle(C_LAT + 2);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
